// File: rtl/game_flow_sched_if.sv
// Signal bundle between the game sequencer and its neighbours: start/restart
// controls, tick, sound sources in; state, run levels, clear and piezo out.
interface game_flow_sched_if #(
   parameter int PITCH_W = 32
);
   logic               i_tick;
   logic               i_start;
   logic               i_restart;
   logic               i_game_end;
   logic               i_intro_en;
   logic [PITCH_W-1:0] i_intro_pitch;
   logic               i_game_en;
   logic [PITCH_W-1:0] i_game_pitch;
   logic [1:0]         o_state;
   logic               o_intro_run;
   logic               o_game_run;
   logic               o_gated_tick;
   logic               o_clear;
   logic [1:0]         o_countdown;
   logic               o_piezo_en;
   logic [PITCH_W-1:0] o_piezo_pitch;

   modport master (
      output i_tick, i_start, i_restart, i_game_end,
             i_intro_en, i_intro_pitch, i_game_en, i_game_pitch,
      input  o_state, o_intro_run, o_game_run, o_gated_tick,
             o_clear, o_countdown, o_piezo_en, o_piezo_pitch
   );

   modport slave (
      input  i_tick, i_start, i_restart, i_game_end,
             i_intro_en, i_intro_pitch, i_game_en, i_game_pitch,
      output o_state, o_intro_run, o_game_run, o_gated_tick,
             o_clear, o_countdown, o_piezo_en, o_piezo_pitch
   );
endinterface

// File: rtl/game_flow_sched.sv
// Rhythm-game flow sequencer (IDLE -> COUNTDOWN 3-2-1 -> PLAY -> END) with
// 1 ms tick gating, restart soft-clear and single-piezo arbitration.
module game_flow_sched #(
   parameter int CNT_STEP_MS = 1000,
   parameter int BEEP_MS     = 100,
   parameter int END_HOLD_MS = 2000,
   parameter int PITCH_W     = 32,
   parameter int PITCH_BEEP  = 25000,
   parameter int PITCH_GO    = 12500
) (
   input logic            clk,
   input logic            rst,
   game_flow_sched_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_COUNTDOWN = 2'd1,
      S_PLAY      = 2'd2,
      S_END       = 2'd3
   } state_t;

   localparam int STEP_W = $clog2(CNT_STEP_MS + 1);
   localparam int GO_W   = $clog2(BEEP_MS + 1);
   localparam int HOLD_W = $clog2(END_HOLD_MS + 1);

   localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(CNT_STEP_MS - 1);
   localparam logic [STEP_W-1:0]  STEP_BEEP = STEP_W'(BEEP_MS);
   localparam logic [GO_W-1:0]    GO_MAX    = GO_W'(BEEP_MS);
   localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(END_HOLD_MS);
   localparam logic [PITCH_W-1:0] BEEP_P    = PITCH_W'(PITCH_BEEP);
   localparam logic [PITCH_W-1:0] GO_P      = PITCH_W'(PITCH_GO);

   state_t              state;
   logic [STEP_W-1:0]   step_cnt;
   logic [GO_W-1:0]     go_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [1:0]          digit;
   logic                clear;

   // NOTE: state registers use non-blocking assignments so every branch reads
   // the pre-edge values and the update order inside the block is irrelevant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         step_cnt <= '0;
         go_cnt   <= '0;
         hold_cnt <= '0;
         digit    <= 2'd0;
         clear    <= 1'b0;
      end else begin
         clear <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.i_start) begin
                  state    <= S_COUNTDOWN;
                  digit    <= 2'd3;
                  step_cnt <= '0;
               end
            end
            S_COUNTDOWN: begin
               if (bus.i_restart) begin
                  clear    <= 1'b1;
                  digit    <= 2'd3;
                  step_cnt <= '0;
               end else if (bus.i_tick) begin
                  if (step_cnt == STEP_LAST) begin
                     step_cnt <= '0;
                     if (digit == 2'd1) begin
                        state  <= S_PLAY;
                        digit  <= 2'd0;
                        go_cnt <= '0;
                     end else begin
                        digit <= digit - 2'd1;
                     end
                  end else begin
                     step_cnt <= step_cnt + 1'b1;
                  end
               end
            end
            S_PLAY: begin
               // Restart wins over a chart end arriving in the same cycle.
               if (bus.i_restart) begin
                  clear    <= 1'b1;
                  state    <= S_COUNTDOWN;
                  digit    <= 2'd3;
                  step_cnt <= '0;
               end else if (bus.i_game_end) begin
                  state    <= S_END;
                  hold_cnt <= '0;
               end else if (bus.i_tick && go_cnt != GO_MAX) begin
                  go_cnt <= go_cnt + 1'b1;
               end
            end
            S_END: begin
               if (bus.i_restart && hold_cnt == HOLD_MAX) begin
                  clear    <= 1'b1;
                  state    <= S_COUNTDOWN;
                  digit    <= 2'd3;
                  step_cnt <= '0;
               end else if (bus.i_tick && hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // en and pitch share one registered selector, so they always switch together.
   always_comb begin
      // NOTE: defaults first keep every path assigned, so no latch is inferred.
      bus.o_piezo_en    = 1'b0;
      bus.o_piezo_pitch = '0;
      case (state)
         S_IDLE: begin
            bus.o_piezo_en    = bus.i_intro_en;
            bus.o_piezo_pitch = bus.i_intro_pitch;
         end
         S_COUNTDOWN: begin
            if (step_cnt < STEP_BEEP) begin
               bus.o_piezo_en    = 1'b1;
               bus.o_piezo_pitch = BEEP_P;
            end
         end
         S_PLAY: begin
            if (go_cnt < GO_MAX) begin
               bus.o_piezo_en    = 1'b1;
               bus.o_piezo_pitch = GO_P;
            end else begin
               bus.o_piezo_en    = bus.i_game_en;
               bus.o_piezo_pitch = bus.i_game_pitch;
            end
         end
         default: ;
      endcase
   end

   assign bus.o_state      = state;
   assign bus.o_intro_run  = (state == S_IDLE);
   assign bus.o_game_run   = (state == S_PLAY);
   assign bus.o_gated_tick = bus.i_tick & (state == S_PLAY);
   assign bus.o_clear      = clear;
   assign bus.o_countdown  = digit;
endmodule

// File: tb/tb_game_flow_sched.sv
// Directed bench for game_flow_sched: a table of {pulses after N ticks,
// expected state/outputs} records plus hand-written reset and tick-gating cases.
module tb_game_flow_sched;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   game_flow_sched_if #(.PITCH_W(32)) bus ();
   game_flow_sched dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      string       name;
      int          ticks;
      logic        start;
      logic        restart;
      logic        gend;
      logic [1:0]  st;
      logic [1:0]  cd;
      logic        clr;
      logic        pen;
      logic [31:0] pitch;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   logic cur_play = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // One clock: drive on the falling edge, check the combinational tick gate,
   // then land just after the rising edge so registered outputs are settled.
   task automatic cycle(input logic t, input logic s, input logic r, input logic g);
      @(negedge clk);
      bus.i_tick = t; bus.i_start = s; bus.i_restart = r; bus.i_game_end = g;
      #1 check("gated_tick", {31'd0, bus.o_gated_tick}, {31'd0, t & cur_play});
      @(posedge clk);
      #1;
   endtask

   task automatic run_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   function automatic vec_t mk(input string name, input int ticks, input logic s, input logic r,
                               input logic g, input logic [1:0] st, input logic [1:0] cd,
                               input logic clr, input logic pen, input logic [31:0] pitch);
      vec_t v;
      v.name = name; v.ticks = ticks; v.start = s; v.restart = r; v.gend = g;
      v.st = st; v.cd = cd; v.clr = clr; v.pen = pen; v.pitch = pitch;
      return v;
   endfunction

   vec_t vecs[21];
   logic [1:0] prev_st;

   initial begin
      //            name            ticks  s  r  g   st cd clr pen pitch
      vecs[0]  = mk("idle_ignore",      0, 0, 1, 1,  0, 0, 0, 1, 777);
      vecs[1]  = mk("start",            5, 1, 0, 0,  1, 3, 0, 1, 25000);
      vecs[2]  = mk("d3_beep_end",     99, 0, 0, 0,  1, 3, 0, 1, 25000);
      vecs[3]  = mk("d3_quiet",         1, 0, 0, 0,  1, 3, 0, 0, 0);
      vecs[4]  = mk("d3_last",        899, 0, 0, 0,  1, 3, 0, 0, 0);
      vecs[5]  = mk("d2_enter",         1, 0, 0, 0,  1, 2, 0, 1, 25000);
      vecs[6]  = mk("d1_enter",      1000, 0, 0, 0,  1, 1, 0, 1, 25000);
      vecs[7]  = mk("d1_last",        999, 0, 0, 0,  1, 1, 0, 0, 0);
      vecs[8]  = mk("play_go",          1, 0, 0, 0,  2, 0, 0, 1, 12500);
      vecs[9]  = mk("go_last",         99, 0, 0, 0,  2, 0, 0, 1, 12500);
      vecs[10] = mk("game_sound",       1, 0, 0, 0,  2, 0, 0, 1, 40000);
      vecs[11] = mk("game_end",         0, 0, 0, 1,  3, 0, 0, 0, 0);
      vecs[12] = mk("early_restart",  500, 0, 1, 0,  3, 0, 0, 0, 0);
      vecs[13] = mk("late_restart",  1500, 0, 1, 0,  1, 3, 1, 1, 25000);
      vecs[14] = mk("after_clear",      1, 0, 0, 0,  1, 3, 0, 1, 25000);
      vecs[15] = mk("d1_last_b",     2998, 0, 0, 0,  1, 1, 0, 0, 0);
      vecs[16] = mk("play_b",           1, 0, 0, 0,  2, 0, 0, 1, 12500);
      vecs[17] = mk("restart_and_end",  0, 0, 1, 1,  1, 3, 1, 1, 25000);
      vecs[18] = mk("cd_start_ign",     0, 1, 0, 0,  1, 3, 0, 1, 25000);
      vecs[19] = mk("cd_restart",     500, 0, 1, 0,  1, 3, 1, 1, 25000);
      vecs[20] = mk("cd_d2_again",   1000, 0, 0, 0,  1, 2, 0, 1, 25000);

      bus.i_tick = 1'b0; bus.i_start = 1'b0; bus.i_restart = 1'b0; bus.i_game_end = 1'b0;
      bus.i_intro_en = 1'b1; bus.i_intro_pitch = 32'd777;
      bus.i_game_en = 1'b1;  bus.i_game_pitch = 32'd40000;

      // Reset state, with intro sound passing through while in reset.
      #12;
      check("rst_state",     {30'd0, bus.o_state}, 32'd0);
      check("rst_countdown", {30'd0, bus.o_countdown}, 32'd0);
      check("rst_intro_run", {31'd0, bus.o_intro_run}, 32'd1);
      check("rst_game_run",  {31'd0, bus.o_game_run}, 32'd0);
      check("rst_clear",     {31'd0, bus.o_clear}, 32'd0);
      check("rst_piezo_en",  {31'd0, bus.o_piezo_en}, 32'd1);
      check("rst_pitch",     bus.o_piezo_pitch, 32'd777);
      @(negedge clk);
      rst = 1'b1;

      prev_st = 2'd0;
      for (int i = 0; i < 21; i++) begin
         cur_play = (prev_st == 2'd2);
         run_ticks(vecs[i].ticks);
         cycle(1'b0, vecs[i].start, vecs[i].restart, vecs[i].gend);
         check({vecs[i].name, ".state"},     {30'd0, bus.o_state}, {30'd0, vecs[i].st});
         check({vecs[i].name, ".countdown"}, {30'd0, bus.o_countdown}, {30'd0, vecs[i].cd});
         check({vecs[i].name, ".clear"},     {31'd0, bus.o_clear}, {31'd0, vecs[i].clr});
         check({vecs[i].name, ".piezo_en"},  {31'd0, bus.o_piezo_en}, {31'd0, vecs[i].pen});
         check({vecs[i].name, ".pitch"},     bus.o_piezo_pitch, vecs[i].pitch);
         check({vecs[i].name, ".intro_run"}, {31'd0, bus.o_intro_run}, {31'd0, vecs[i].st == 2'd0});
         check({vecs[i].name, ".game_run"},  {31'd0, bus.o_game_run}, {31'd0, vecs[i].st == 2'd2});
         prev_st = vecs[i].st;
         cur_play = (prev_st == 2'd2);
         if (vecs[i].clr) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            check({vecs[i].name, ".clear_drop"}, {31'd0, bus.o_clear}, 32'd0);
         end
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of digit 2 takes effect immediately.
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("async_rst.state",     {30'd0, bus.o_state}, 32'd0);
      check("async_rst.countdown", {30'd0, bus.o_countdown}, 32'd0);
      check("async_rst.intro_run", {31'd0, bus.o_intro_run}, 32'd1);
      check("async_rst.clear",     {31'd0, bus.o_clear}, 32'd0);
      check("async_rst.pitch",     bus.o_piezo_pitch, 32'd777);
      @(negedge clk);
      rst = 1'b1;
      cur_play = 1'b0;
      run_ticks(3);
      check("post_rst.state", {30'd0, bus.o_state}, 32'd0);
      check("post_rst.clear", {31'd0, bus.o_clear}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
